// File: rtl/bf_pkg.sv
// ============================================================================
// Module      : bf_pkg
// Description : Shared state encoding and helpers for the Bellman-Ford
//               iteration controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package bf_pkg;

  localparam int DEFAULT_NUM_NODES = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_INIT   = 3'd1,
    ST_WAIT   = 3'd2,
    ST_PROC   = 3'd3,
    ST_COMMIT = 3'd4,
    ST_DONE   = 3'd5
  } bf_state_e;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

endpackage

`default_nettype wire

// File: rtl/bf_phase_counter.sv
// ============================================================================
// Module      : bf_phase_counter
// Description : Loadable down-counter timing the INIT and WAIT dwell phases.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bf_phase_counter #(
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst_global_n,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_value,
  input  logic             i_enable,
  output logic             o_zero
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clk) begin
    if (!rst_global_n) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_value;
    end else if (i_enable && (r_count != '0)) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_zero = (r_count == '0);

endmodule

`default_nettype wire

// File: rtl/bf_iter_controller.sv
// ============================================================================
// Module      : bf_iter_controller
// Description : Sequences bounded Bellman-Ford relaxation passes with early
//               convergence exit and a final no-write negative-cycle check.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bf_iter_controller
  import bf_pkg::*;
#(
  parameter int NUM_NODES   = DEFAULT_NUM_NODES,
  parameter int INIT_CYCLES = 1,
  parameter int WAIT_CYCLES = 1,
  parameter int ITER_W      = clog2(NUM_NODES) + 1
) (
  input  logic              clk,
  input  logic              rst_global_n,
  input  logic              start,
  input  logic              abort,
  input  logic              iteration_done,
  input  logic              relax_changed,
  output logic              read_enable,
  output logic              write_enable,
  output logic              busy,
  output logic              done,
  output logic              converged,
  output logic              neg_cycle,
  output logic [ITER_W-1:0] iter_count
);

  localparam int c_dwell_max = (INIT_CYCLES > WAIT_CYCLES) ? INIT_CYCLES : WAIT_CYCLES;
  localparam int c_cnt_w     = clog2(c_dwell_max) + 1;

  localparam logic [ITER_W-1:0]  c_max_iter  = ITER_W'(NUM_NODES - 1);
  localparam logic [c_cnt_w-1:0] c_init_load = c_cnt_w'(INIT_CYCLES - 1);
  localparam logic [c_cnt_w-1:0] c_wait_load = c_cnt_w'(WAIT_CYCLES - 1);

  bf_state_e          r_state;
  bf_state_e          w_state_next;
  logic               r_changed;
  logic               r_check;
  logic               r_converged;
  logic               r_neg_cycle;
  logic [ITER_W-1:0]  r_iter;
  logic [ITER_W-1:0]  w_iter_inc;
  logic               w_changed_upd;
  logic               w_start_accept;
  logic               w_abort;
  logic               w_done_conv;
  logic               w_done_neg;
  logic               w_cnt_load;
  logic [c_cnt_w-1:0] w_cnt_value;
  logic               w_cnt_enable;
  logic               w_cnt_zero;

  assign w_changed_upd  = r_changed | relax_changed;
  assign w_start_accept = (r_state == ST_IDLE) && start && !abort;
  assign w_abort        = abort && (r_state != ST_IDLE);
  assign w_iter_inc     = r_iter + 1'b1;
  assign w_cnt_enable   = (r_state == ST_INIT) || (r_state == ST_WAIT);

  bf_phase_counter #(
    .WIDTH (c_cnt_w)
  ) u_phase_counter (
    .clk          (clk),
    .rst_global_n (rst_global_n),
    .i_load       (w_cnt_load),
    .i_load_value (w_cnt_value),
    .i_enable     (w_cnt_enable),
    .o_zero       (w_cnt_zero)
  );

  always_ff @(posedge clk) begin
    if (!rst_global_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_cnt_load   = 1'b0;
    w_cnt_value  = '0;
    w_done_conv  = 1'b0;
    w_done_neg   = 1'b0;
    read_enable  = 1'b0;
    write_enable = 1'b0;
    busy         = (r_state != ST_IDLE);
    done         = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (w_start_accept) begin
          w_state_next = ST_INIT;
          w_cnt_load   = 1'b1;
          w_cnt_value  = c_init_load;
        end
      end
      ST_INIT: begin
        read_enable = 1'b1;
        if (w_cnt_zero) begin
          w_state_next = ST_WAIT;
          w_cnt_load   = 1'b1;
          w_cnt_value  = c_wait_load;
        end
      end
      ST_WAIT: begin
        if (w_cnt_zero) w_state_next = ST_PROC;
      end
      ST_PROC: begin
        // Decision uses the flag including this cycle's relax_changed.
        if (iteration_done) begin
          if (!r_check && w_changed_upd) begin
            w_state_next = ST_COMMIT;
          end else begin
            w_state_next = ST_DONE;
            w_done_neg   = r_check && w_changed_upd;
            w_done_conv  = !w_changed_upd;
          end
        end
      end
      ST_COMMIT: begin
        read_enable  = 1'b1;
        write_enable = !r_check;
        w_state_next = ST_WAIT;
        w_cnt_load   = 1'b1;
        w_cnt_value  = c_wait_load;
      end
      ST_DONE: begin
        done         = 1'b1;
        w_state_next = ST_IDLE;
      end
      default: begin
        w_state_next = ST_IDLE;
        busy         = 1'b0;
      end
    endcase

    if (w_abort) begin
      w_state_next = ST_IDLE;
      w_done_conv  = 1'b0;
      w_done_neg   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_global_n) begin
      r_changed   <= 1'b0;
      r_check     <= 1'b0;
      r_converged <= 1'b0;
      r_neg_cycle <= 1'b0;
      r_iter      <= '0;
    end else begin
      // Outside PROC the flag is held clear, so every WAIT entry starts fresh.
      r_changed <= (r_state == ST_PROC) && w_changed_upd;
      if (w_abort) begin
        r_converged <= 1'b0;
        r_neg_cycle <= 1'b0;
      end else begin
        if (w_start_accept) begin
          r_iter      <= '0;
          r_converged <= 1'b0;
          r_neg_cycle <= 1'b0;
          r_check     <= 1'b0;
        end
        if (w_done_conv) r_converged <= 1'b1;
        if (w_done_neg)  r_neg_cycle <= 1'b1;
        if (r_state == ST_COMMIT) begin
          r_iter <= w_iter_inc;
          if (w_iter_inc == c_max_iter) r_check <= 1'b1;
        end
      end
    end
  end

  assign converged  = r_converged;
  assign neg_cycle  = r_neg_cycle;
  assign iter_count = r_iter;

endmodule

`default_nettype wire

// File: doc/bf_iter_controller.md
Name: bf_iter_controller

Overview:
- Parametrised successor of the Bellman-Ford iteration controller.
- Sequences relaxation passes over the distance memory: init read, pipeline wait, process, commit.
- Adds a bounded iteration count of NUM_NODES-1, early exit on convergence, an extra no-write check pass for negative-cycle detection, configurable init/wait lengths, and abort.
- Sits between the AGU/relaxation datapath and the distance RAM write/read strobes.

Parameters:
- NUM_NODES, 8, graph node count; relaxation passes max = NUM_NODES-1; legal range >= 2.
- INIT_CYCLES, 1, cycles spent in INIT (read_enable high); legal range >= 1.
- WAIT_CYCLES, 1, pipeline-fill cycles before PROC; legal range >= 1.
- ITER_W, $clog2(NUM_NODES)+1, width of iter_count.

Ports:
- clk  in  1  rising-edge clock
- rst_global_n  in  1  synchronous, active-low reset
- start  in  1  begin run; sampled only in IDLE
- abort  in  1  terminate run from any state
- iteration_done  in  1  AGU: current pass finished; honoured only in PROC
- relax_changed  in  1  datapath: a distance improved this cycle; honoured only in PROC
- read_enable  out  1  distance RAM read strobe
- write_enable  out  1  distance RAM write/commit strobe
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse at normal run completion
- converged  out  1  run ended with no change; sticky until next accepted start
- neg_cycle  out  1  check pass still relaxed; sticky until next accepted start
- iter_count  out  ITER_W  committed passes in current/last run

Behaviour:
- Reset (rst_global_n=0 at a clk edge):
  - state=IDLE.
  - All outputs 0, all counters 0, changed flag 0, check flag 0.
  - Reset mid-run discards the run with no done pulse.
- Outputs are Moore-style, decoded from registered state and flags; no combinational input-to-output path.
- States: IDLE, INIT, WAIT, PROC, COMMIT, DONE.
- IDLE:
  - Outputs 0.
  - start=1 -> INIT. Clears iter_count, converged, neg_cycle, changed flag and check flag.
- INIT:
  - read_enable=1.
  - Stays exactly INIT_CYCLES cycles, then -> WAIT.
- WAIT:
  - read_enable=0, write_enable=0.
  - Stays exactly WAIT_CYCLES cycles, then -> PROC.
  - Changed flag is cleared on entry.
- PROC:
  - Changed flag |= relax_changed every cycle, including the cycle iteration_done=1.
  - On iteration_done=1, the next state is chosen using the updated flag:
    - Check flag=0 and changed=0 -> DONE with converged=1. No write; iter_count unchanged.
    - Check flag=0 and changed=1 -> COMMIT.
    - Check flag=1 and changed=1 -> DONE with neg_cycle=1.
    - Check flag=1 and changed=0 -> DONE with converged=1.
- COMMIT (1 cycle):
  - write_enable=1, read_enable=1; iter_count+1.
  - If the incremented count == NUM_NODES-1, set check flag.
  - Always -> WAIT.
- Check pass: write_enable is never asserted while the check flag=1.
- DONE (1 cycle): done=1, then -> IDLE. converged/neg_cycle stay held in IDLE.
- abort=1 in any non-IDLE state:
  - Next state IDLE; highest priority over iteration_done and start.
  - Forces write_enable=0 and read_enable=0 from the next cycle.
  - No done pulse. converged and neg_cycle are cleared; iter_count is held.
- start while busy: ignored. iteration_done outside PROC: ignored.
- Minimum latency, start to first write_enable: 1 + INIT_CYCLES + WAIT_CYCLES + 1(PROC) cycles, measured as the COMMIT cycle index.
- iter_count never exceeds NUM_NODES-1. No wrap is possible given ITER_W.
- Illegal state encodings -> IDLE.

Decomposition:
- Shared package bf_pkg holds:
  - State enum (IDLE, INIT, WAIT, PROC, COMMIT, DONE).
  - Function clog2.
  - Constant DEFAULT_NUM_NODES=8.
- One sub-module: bf_phase_counter, a loadable down-counter used for the INIT and WAIT dwell, with load value, enable and zero flag. The FSM and iteration counter stay in bf_iter_controller.

Test Plan:
- Reset/idle: hold rst_global_n=0 for 3 cycles, then release with start=0 -> all outputs 0, busy=0, iter_count=0. Pulse start, then reset mid-PROC -> IDLE next cycle, no done.
- Early convergence (NUM_NODES=8, INIT=1, WAIT=1): two passes with relax_changed, third pass without -> exactly 2 write_enable pulses, iter_count=2, converged=1, done pulse, neg_cycle=0.
- Full run without negative cycle: 7 passes with changes, check pass none -> 7 write_enable pulses, 8th pass no write, converged=1, iter_count=7.
- Negative cycle: changes on every pass including the check pass -> 7 writes, neg_cycle=1, converged=0, done pulses once.
- Timing with INIT_CYCLES=3, WAIT_CYCLES=2: start at cycle 0 -> read_enable high cycles 1-3, PROC from cycle 6. iteration_done+relax_changed at cycle 6 -> write_enable at cycle 7, PROC again at cycle 10.
- Abort/ignore: abort asserted in the same cycle as iteration_done in PROC -> IDLE, no write, no done. start while busy and iteration_done in WAIT -> no effect.
